// File: rtl/hazard_ctrl_pipe_pkg.sv
// Shared constants for the pipeline control carrier: bundle widths, bit positions
// inside each control bundle, and the forwarding select encodings.
package hazard_ctrl_pipe_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 2;
    localparam int EX_W = 4;

    // WB bundle {RegWrite, MemToReg}
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;
    // M bundle {MemRead, MemWrite}
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;
    // EX bundle {RegDest, ALUOp[1:0], ALUSrc}
    localparam int REGDEST  = 3;
    localparam int ALUSRC   = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/hazard_ctrl_pipe_fwd_unit.sv
// Forwarding select for a single ALU operand; EX/MEM results take precedence
// over MEM/WB because they are younger.
module hazard_ctrl_pipe_fwd_unit
    import hazard_ctrl_pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_dest,
    output logic [1:0]      fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_regwrite && (mem_dest != '0) && (mem_dest == src)) begin
            fwd = FWD_MEM;
        end else if (wb_regwrite && (wb_dest != '0) && (wb_dest == src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control carrier with stall, flush and forwarding control.
// Define FORWARD_EN to build operand forwarding; otherwise every RAW hazard stalls.
module hazard_ctrl_pipe
    import hazard_ctrl_pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EX_W-1:0]  id_ex,
    input  logic             id_jump,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             mem_branch_taken,
    output logic [EX_W-1:0]  ex_ctrl,
    output logic [M_W-1:0]   ex_m,
    output logic [WB_W-1:0]  ex_wb,
    output logic [M_W-1:0]   mem_m,
    output logic [WB_W-1:0]  mem_wb,
    output logic [WB_W-1:0]  wb_wb,
    output logic [RA_W-1:0]  ex_dest,
    output logic [RA_W-1:0]  mem_dest,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush
);

    logic [EX_W-1:0] ex_ctrl_q, ex_ctrl_d;
    logic [M_W-1:0]  ex_m_q, ex_m_d;
    logic [WB_W-1:0] ex_wb_q, ex_wb_d;
    logic [RA_W-1:0] ex_dest_q, ex_dest_d;
    logic [M_W-1:0]  mem_m_q, mem_m_d;
    logic [WB_W-1:0] mem_wb_q, mem_wb_d;
    logic [RA_W-1:0] mem_dest_q, mem_dest_d;
    logic [WB_W-1:0] wb_wb_q;
    logic [RA_W-1:0] wb_dest_q;

    logic flush;
    logic stall;
    logic ex_hit;

    assign flush  = mem_branch_taken;
    assign ex_hit = (ex_dest_q != '0) && ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));

`ifdef FORWARD_EN
    logic [RA_W-1:0] ex_rs_q, ex_rt_q;

    // Only a load in EX cannot be covered by forwarding.
    assign stall = ex_m_q[MEMREAD] && ex_hit;

    always_ff @(posedge clk) begin
        if (rst || flush || stall) begin
            ex_rs_q <= '0;
            ex_rt_q <= '0;
        end else begin
            ex_rs_q <= id_rs;
            ex_rt_q <= id_rt;
        end
    end

    hazard_ctrl_pipe_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .src          (ex_rs_q),
        .mem_regwrite (mem_wb_q[REGWRITE]),
        .mem_dest     (mem_dest_q),
        .wb_regwrite  (wb_wb_q[REGWRITE]),
        .wb_dest      (wb_dest_q),
        .fwd          (fwd_a)
    );

    hazard_ctrl_pipe_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .src          (ex_rt_q),
        .mem_regwrite (mem_wb_q[REGWRITE]),
        .mem_dest     (mem_dest_q),
        .wb_regwrite  (wb_wb_q[REGWRITE]),
        .wb_dest      (wb_dest_q),
        .fwd          (fwd_b)
    );
`else
    logic mem_hit;

    // Regfile writes in the first half-cycle, so MEM/WB producers never stall.
    assign mem_hit = (mem_dest_q != '0) && ((mem_dest_q == id_rs) || (mem_dest_q == id_rt));
    assign stall   = (ex_wb_q[REGWRITE] && ex_hit) || (mem_wb_q[REGWRITE] && mem_hit);
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
`endif

    assign pc_write   = flush || !stall;
    assign ifid_write = flush || !stall;
    assign ifid_flush = flush || (id_jump && !stall);

    always_comb begin
        ex_ctrl_d  = id_ex;
        ex_m_d     = id_m;
        ex_wb_d    = id_wb;
        ex_dest_d  = id_ex[REGDEST] ? id_rd : id_rt;
        mem_m_d    = ex_m_q;
        mem_wb_d   = ex_wb_q;
        mem_dest_d = ex_dest_q;
        if (flush || stall) begin
            ex_ctrl_d = '0;
            ex_m_d    = '0;
            ex_wb_d   = '0;
            ex_dest_d = '0;
        end
        if (flush) begin
            mem_m_d    = '0;
            mem_wb_d   = '0;
            mem_dest_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q  <= '0;
            ex_m_q     <= '0;
            ex_wb_q    <= '0;
            ex_dest_q  <= '0;
            mem_m_q    <= '0;
            mem_wb_q   <= '0;
            mem_dest_q <= '0;
            wb_wb_q    <= '0;
            wb_dest_q  <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            ex_m_q     <= ex_m_d;
            ex_wb_q    <= ex_wb_d;
            ex_dest_q  <= ex_dest_d;
            mem_m_q    <= mem_m_d;
            mem_wb_q   <= mem_wb_d;
            mem_dest_q <= mem_dest_d;
            // The branch itself still retires through MEM/WB.
            wb_wb_q    <= mem_wb_q;
            wb_dest_q  <= mem_dest_q;
        end
    end

    assign ex_ctrl  = ex_ctrl_q;
    assign ex_m     = ex_m_q;
    assign ex_wb    = ex_wb_q;
    assign ex_dest  = ex_dest_q;
    assign mem_m    = mem_m_q;
    assign mem_wb   = mem_wb_q;
    assign mem_dest = mem_dest_q;
    assign wb_wb    = wb_wb_q;
    assign wb_dest  = wb_dest_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed self-checking bench for hazard_ctrl_pipe; follows the FORWARD_EN build
// of the design so expectations match whichever configuration is compiled.
module tb_hazard_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] id_wb, id_m;
    logic [3:0] id_ex;
    logic       id_jump;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       mem_branch_taken;
    logic [3:0] ex_ctrl;
    logic [1:0] ex_m, ex_wb, mem_m, mem_wb, wb_wb;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_write, ifid_write, ifid_flush;

    int errors = 0;
    int checks = 0;

    hazard_ctrl_pipe #(.RA_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_wb            (id_wb),
        .id_m             (id_m),
        .id_ex            (id_ex),
        .id_jump          (id_jump),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .mem_branch_taken (mem_branch_taken),
        .ex_ctrl          (ex_ctrl),
        .ex_m             (ex_m),
        .ex_wb            (ex_wb),
        .mem_m            (mem_m),
        .mem_wb           (mem_wb),
        .wb_wb            (wb_wb),
        .ex_dest          (ex_dest),
        .mem_dest         (mem_dest),
        .wb_dest          (wb_dest),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .pc_write         (pc_write),
        .ifid_write       (ifid_write),
        .ifid_flush       (ifid_flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then leave 1 time unit so register outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                          input logic j, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        id_wb   = wb;
        id_m    = m;
        id_ex   = ex;
        id_jump = j;
        id_rs   = rs;
        id_rt   = rt;
        id_rd   = rd;
        #1;
    endtask

    task automatic nop();
        set_id(2'b00, 2'b00, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic drain();
        nop();
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        mem_branch_taken = 1'b0;
        nop();
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Idle after reset
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_m", ex_m, 0);
        chk("rst_ex_wb", ex_wb, 0);
        chk("rst_mem_m", mem_m, 0);
        chk("rst_mem_wb", mem_wb, 0);
        chk("rst_wb_wb", wb_wb, 0);
        chk("rst_dests", {ex_dest, mem_dest, wb_dest}, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        chk("rst_pc_write", pc_write, 1);
        chk("rst_ifid_write", ifid_write, 1);
        chk("rst_ifid_flush", ifid_flush, 0);

        // lw r8 followed by add r10 = r8 + r9
        set_id(2'b11, 2'b10, 4'b0001, 1'b0, 5'd1, 5'd8, 5'd0);
        chk("lw_no_stall", pc_write, 1);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd8, 5'd9, 5'd10);
        chk("lu_pc_write", pc_write, 0);
        chk("lu_ifid_write", ifid_write, 0);
        chk("lu_ex_dest", ex_dest, 8);
        tick();
        chk("lu_bubble_ctrl", {ex_ctrl, ex_m, ex_wb, ex_dest}, 0);
        chk("lu_mem_m", mem_m, 2'b10);
`ifdef FORWARD_EN
        chk("lu_resume", pc_write, 1);
        tick();
        chk("lu_add_in_ex", ex_ctrl, 4'b1100);
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);
`else
        chk("lu_stall2", pc_write, 0);
        tick();
        chk("lu_resume", pc_write, 1);
        tick();
        chk("lu_add_in_ex", ex_ctrl, 4'b1100);
        chk("lu_fwd_a", fwd_a, 2'b00);
`endif
        drain();

        // Writes to $0 never create a hazard or a forward
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd0, 5'd0, 5'd4);
        chk("r0_no_stall", pc_write, 1);
        tick();
        chk("r0_ex_dest", ex_dest, 4);
        chk("r0_fwd", {fwd_a, fwd_b}, 0);
        drain();

`ifdef FORWARD_EN
        // add r3 then sub r5 = r3 - r4: EX/MEM forward, no stall
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd1, 5'd2, 5'd3);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd3, 5'd4, 5'd5);
        chk("alu_no_stall", pc_write, 1);
        tick();
        chk("alu_fwd_a", fwd_a, 2'b10);
        chk("alu_fwd_b", fwd_b, 2'b00);
        chk("alu_mem_dest", mem_dest, 3);
`else
        // add r5 then or r6 = r5 | r7: two stall cycles
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd1, 5'd2, 5'd5);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd5, 5'd7, 5'd6);
        chk("raw_stall1", pc_write, 0);
        tick();
        chk("raw_stall2", pc_write, 0);
        chk("raw_ifid_write2", ifid_write, 0);
        tick();
        chk("raw_resume", pc_write, 1);
        tick();
        chk("raw_or_dest", ex_dest, 6);
        chk("raw_fwd_a", fwd_a, 2'b00);
`endif
        drain();

        // Taken branch with valid instructions in ID/EX and EX/MEM
        set_id(2'b00, 2'b00, 4'b0010, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd1, 5'd2, 5'd6);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd1, 5'd2, 5'd7);
        mem_branch_taken = 1'b1;
        #1;
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_pc_write", pc_write, 1);
        tick();
        mem_branch_taken = 1'b0;
        nop();
        chk("br_ex_bubble", {ex_ctrl, ex_m, ex_wb, ex_dest}, 0);
        chk("br_mem_bubble", {mem_m, mem_wb, mem_dest}, 0);
        chk("br_wb_wb", wb_wb, 2'b00);
        chk("br_wb_dest", wb_dest, 2);
        drain();

        // Load-use stall coinciding with a taken branch: flush wins
        set_id(2'b00, 2'b00, 4'b0010, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        set_id(2'b11, 2'b10, 4'b0001, 1'b0, 5'd1, 5'd8, 5'd0);
        tick();
        set_id(2'b10, 2'b00, 4'b1100, 1'b0, 5'd8, 5'd9, 5'd10);
        mem_branch_taken = 1'b1;
        #1;
        chk("bs_pc_write", pc_write, 1);
        chk("bs_ifid_flush", ifid_flush, 1);
        tick();
        mem_branch_taken = 1'b0;
        nop();
        chk("bs_ex_bubble", {ex_ctrl, ex_m, ex_wb}, 0);
        chk("bs_mem_bubble", {mem_m, mem_wb}, 0);
        drain();

        // Jump: flushes IF/ID unless a stall holds it
        set_id(2'b00, 2'b00, 4'b0000, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("j_ifid_flush", ifid_flush, 1);
        chk("j_pc_write", pc_write, 1);
        set_id(2'b11, 2'b10, 4'b0001, 1'b0, 5'd1, 5'd8, 5'd0);
        tick();
        set_id(2'b00, 2'b00, 4'b0000, 1'b1, 5'd8, 5'd0, 5'd0);
        chk("js_ifid_flush", ifid_flush, 0);
        chk("js_pc_write", pc_write, 0);

        // Reset in the middle of the stall clears everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nop();
        chk("rs_stages", {ex_m, ex_wb, mem_m, mem_wb, wb_wb}, 0);
        chk("rs_pc_write", pc_write, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
# hazard_ctrl_pipe

Pipeline control carrier and hazard unit for the 5-stage MIPS datapath. It consumes the WB/M/EX control bundles and register fields produced in ID, and registers them through the ID/EX, EX/MEM and MEM/WB stages. It detects load-use (or general RAW) hazards and inserts bubbles, flushes younger stages on taken branches and jumps, and generates ALU operand forwarding selects.

## Interface
Parameters:
- RA_W, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_wb  in  2  {RegWrite, MemToReg} from ID decode
- id_m  in  2  {MemRead, MemWrite} from ID decode
- id_ex  in  4  {RegDest, ALUOp[1:0], ALUSrc} from ID decode
- id_jump  in  1  Jump decoded in ID
- id_rs, id_rt, id_rd  in  RA_W  register fields of the ID instruction
- mem_branch_taken  in  1  Branch & zero, resolved for the instruction in EX/MEM
- ex_ctrl  out  4  ID/EX EX bundle
- ex_m, ex_wb  out  2  ID/EX M and WB bundles
- mem_m, mem_wb  out  2  EX/MEM bundles
- wb_wb  out  2  MEM/WB WB bundle
- ex_dest, mem_dest, wb_dest  out  RA_W  destination register per stage
- fwd_a, fwd_b  out  2  ALU operand select: 00 = regfile, 10 = EX/MEM, 01 = MEM/WB
- pc_write  out  1  PC enable
- ifid_write  out  1  IF/ID enable
- ifid_flush  out  1  clear IF/ID to NOP

## Operation
- ID/EX stores id_wb, id_m, id_ex, id_rs, id_rt, and dest = RegDest ? id_rd : id_rt.
- EX/MEM and MEM/WB shift forward by one stage each cycle. Bundles not needed downstream are dropped.
- Bubble = all control bits 0, dest 0.
- Load-use stall condition: ex_m[1] & ex_dest≠0 & (ex_dest==id_rs | ex_dest==id_rt).
- On stall: pc_write=0, ifid_write=0, and ID/EX loads a bubble. EX/MEM and MEM/WB advance normally.
- Branch flush, on mem_branch_taken=1:
  - ifid_flush=1.
  - ID/EX and EX/MEM load bubbles.
  - MEM/WB loads the branch's own EX/MEM contents.
  - pc_write=1.
- Jump, on id_jump=1 and no stall: ifid_flush=1. The jump itself enters ID/EX as decoded.
- Priority: flush > stall > jump. When a flush and a stall coincide, the flush wins and pc_write=1.
- Forwarding for operand A (B is identical using ex_rt):
  - 10 if mem_wb[1] & mem_dest≠0 & mem_dest==ex_rs;
  - else 01 if wb_wb[1] & wb_dest≠0 & wb_dest==ex_rs;
  - else 00.
- Register $0 never matches in either hazard or forwarding logic.

## Timing
- All stage registers update on the rising edge of clk.
- pc_write, ifid_write, ifid_flush, fwd_a and fwd_b are combinational from the current register state and ID inputs, with zero added latency.
- Reset: every stage bundle and dest resets to 0. Consequently pc_write=1, ifid_write=1, ifid_flush=0, fwd_a=fwd_b=00 in the first cycle after reset.
- rst asserted mid-stall or mid-flush clears all state at the next edge. rst dominates all other inputs.
- A load-use stall lasts exactly 1 cycle, because the load advances to EX/MEM and the condition clears.
- A taken branch costs 3 bubbles: IF/ID, ID/EX and EX/MEM.

## Configuration
- FORWARD_EN defined:
  - Forwarding logic is present as above.
  - Only load-use hazards stall.
- FORWARD_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - The stall condition widens to any RAW hazard: (ex_wb[1] & ex_dest match) | (mem_wb[1] & mem_dest match) against id_rs/id_rt, with dest≠0.
  - Stalls last up to 2 cycles.
  - The register file writes in the first half of the cycle, so MEM/WB needs no stall.

## Structure
- Shared package holds:
  - bundle widths (WB_W=2, M_W=2, EX_W=4);
  - bit index constants (REGWRITE, MEMTOREG, MEMREAD, MEMWRITE, REGDEST, ALUSRC);
  - fwd select encodings FWD_RF, FWD_MEM, FWD_WB.
- One sub-module, fwd_unit: purely combinational forwarding select for one operand, instantiated twice. It is omitted when FORWARD_EN is undefined.

## Test plan
- Reset, then idle with zero inputs → all outputs 0 except pc_write=ifid_write=1.
- lw r8 (id_m=10, id_wb=11, id_ex=0001, rt=8) followed by add using rs=8 → one cycle with pc_write=0, ifid_write=0, ex bundles zero; the next cycle has pc_write=1 and fwd_a=01 when the add reaches EX.
- add r3 (RegDest=1, rd=3) then sub rs=3 (FORWARD_EN) → fwd_a=10 in the sub's EX cycle, and no stall.
- mem_branch_taken=1 with valid instructions in ID/EX and EX/MEM → ifid_flush=1; next cycle ex_* and mem_* are zero, and wb_wb equals the branch's mem_wb (00).
- Load-use stall and mem_branch_taken in the same cycle → flush wins: pc_write=1, ifid_flush=1, both stages bubbled.
- Without FORWARD_EN: add r5 then or rs=5 → two stall cycles, then the or enters EX with fwd_a=00.
